buffer_to_mpf_wr_sm: RTL
========================

Name: buffer_to_mpf_wr_sm

Overview:
- Write-back stage of the generic processing pipeline. Drains result cache lines from the output buffer, which is filled by the processing core. Writes them to host memory through MPF as single-line virtual-address write requests on c1Tx.
- Counts write responses on c1Rx. Signals done only after every line is acknowledged.
- Mirror of the read-side request SM; together they bracket the processing core.

Parameters:
- MAX_OUTSTANDING, 64: maximum write requests in flight (issued, not yet acknowledged); range 1..512.
- MDATA_TAG, 16'h0: constant mdata field placed in every write header.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low.
- run  input  1  single-cycle start pulse; honoured only in IDLE.
- data_length  input  64  cache lines to write; sampled on run.
- first_clAddr  input  t_cci_clAddr  first destination VA (line address); sampled on run.
- done  output  1  registered; high from completion until next accepted run.
- fiu  interface  cci_mpf_if.to_fiu  uses c1Tx, c1TxAlmFull, c1Rx only; c0Tx and c2Tx are driven not-valid.
- buffer_rd_enable  output  1  pop strobe to the output buffer.
- buffer_data  input  512  buffer read data, valid the cycle after buffer_rd_enable.
- buffer_empty  input  1  buffer holds no entries.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; done=0; fiu.c1Tx.valid=0; buffer_rd_enable=0; all counters 0.
  - Outstanding responses arriving after reset are ignored.
- Run latching: on run in IDLE, latch len_q=data_length and base_q=first_clAddr, and clear req_cnt, rsp_cnt and pop_cnt (all 64-bit) and done.
  - Next state: RUN if data_length!=0, else DONE.
  - run in any state other than IDLE is ignored.
- States:
  - IDLE: wait for run.
  - RUN: pop and issue requests.
  - WAIT_RSP: all lines issued, waiting for acknowledgements.
  - DONE: one cycle; sets done=1, then returns to IDLE. done stays 1 in IDLE.
- Pop condition (combinational buffer_rd_enable, RUN only), all of:
  - !buffer_empty
  - !fiu.c1TxAlmFull
  - pop_cnt < len_q
  - (pop_cnt - rsp_cnt) < MAX_OUTSTANDING
- Pop accounting: pop_cnt increments on each pop. Pops count toward the outstanding limit immediately, so no overshoot is possible.
- Issue:
  - A pop at cycle N produces a registered fiu.c1Tx.valid=1 at cycle N+1. Fixed latency: 1 cycle from pop to valid.
  - Request fields: data=buffer_data; address=base_q+req_cnt; eREQ_WRLINE_I; eVC_VA; eCL_LEN_1; sop=1; mdata=MDATA_TAG; virtual addressing.
  - req_cnt increments when c1Tx.valid is driven.
- AlmFull tolerance: c1TxAlmFull asserting between the pop and the issue does not cancel the in-flight request. At most one request is issued after almFull rises, which is within the CCI almost-full slack.
- RUN -> WAIT_RSP when req_cnt==len_q, after the last request has registered.
- Responses:
  - Each cycle with cci_c1Rx_isWriteRsp(fiu.c1Rx) increments rsp_cnt by 1. Single-line writes guarantee one response per request; a packed-format response is not expected.
  - Responses are counted in RUN and WAIT_RSP.
  - A response coinciding with a pop is handled in the same cycle: both counters update and the outstanding calculation uses registered values.
- WAIT_RSP -> DONE when rsp_cnt==len_q.
- Arithmetic and widths:
  - Address addition is modulo t_cci_clAddr width; VA wrap is not checked.
  - Counters are 64-bit, so no wrap within a legal len.
- Buffer behaviour:
  - Empty mid-transfer: stall with no pop and no valid; resume when not empty, no data loss.
  - Extra entries beyond len_q are left in the buffer.
- Simultaneous events:
  - run and reset together: reset wins.
  - reset mid-RUN aborts; no done pulse is produced.
- Simulation: $display on each issued write (byte VA) and each response count.

Decomposition:
- Shared package (generic_processing_pkg): t_wr_state enum {IDLE,RUN,WAIT_RSP,DONE}; CL_DATA_W=512; default MAX_OUTSTANDING.
- MPF header types come from cci_mpf_if.vh.
- One natural sub-module: wr_credit_counter, which tracks outstanding writes and produces the "credit available" flag, from pop and response strobes.

Test Plan:
- Basic transfer: len=8, base=0x1000, buffer preloaded with 8 lines, immediate responses -> 8 writes to lines 0x1000..0x1007 in order, with data matching the buffer; done=1 after the 8th response; buffer_rd_enable high exactly 8 cycles.
- Zero length: len=0 run -> no c1Tx.valid ever; done=1 two cycles after run.
- Outstanding limit: MAX_OUTSTANDING=4, len=16, responses withheld -> exactly 4 writes issued, then stall. Releasing one response allows exactly one more write. done is raised only after 16 responses.
- almFull and empty throttling: almFull held 20 cycles mid-transfer, and the buffer goes empty for 10 cycles -> at most 1 write after almFull rises, no pops while either condition holds, all 32 lines written exactly once with correct addresses.
- Pop/response overlap and restart: len=4, a response coincides with each pop -> rsp_cnt and pop_cnt are both correct and done is set. A second run with base=0x2000, len=2 clears done and writes 0x2000 and 0x2001.
- Abort: reset asserted mid-transfer after 3 of 10 writes -> valid=0, done=0, state IDLE next cycle. A late response is ignored, and a subsequent run behaves normally.

Source files
------------

// File: rtl/cci_mpf_pkg.sv
// cci_mpf_pkg: CCI-P/MPF request and response types seen by the write-back path.
package cci_mpf_pkg;
  localparam int CCI_CLADDR_WIDTH = 42;
  localparam int CCI_CLDATA_WIDTH = 512;
  localparam int CCI_MDATA_WIDTH = 16;
  typedef logic [CCI_CLADDR_WIDTH-1:0] t_cci_clAddr;
  typedef logic [CCI_CLDATA_WIDTH-1:0] t_cci_clData;
  typedef logic [CCI_MDATA_WIDTH-1:0] t_cci_mdata;
  typedef enum logic [1:0] {eVC_VA = 2'h0, eVC_VL0 = 2'h1, eVC_VH0 = 2'h2, eVC_VH1 = 2'h3} t_cci_vc;
  typedef enum logic [1:0] {eCL_LEN_1 = 2'h0, eCL_LEN_2 = 2'h1, eCL_LEN_4 = 2'h3} t_cci_clLen;
  typedef enum logic [3:0] {eREQ_WRLINE_I = 4'h0, eREQ_WRLINE_M = 4'h1, eREQ_WRFENCE = 4'h4} t_cci_c1_req;
  typedef enum logic [3:0] {eRSP_RDLINE = 4'h0, eRSP_WRLINE = 4'h1, eRSP_WRFENCE = 4'h4} t_cci_rsp;
  typedef struct packed {
    logic addrIsVirtual;
    logic mapVAtoPhysChannel;
    logic checkLoadStoreOrder;
    t_cci_vc vc_sel;
    logic sop;
    t_cci_clLen cl_len;
    t_cci_c1_req req_type;
    t_cci_clAddr address;
    t_cci_mdata mdata;
  } t_cci_mpf_c1_ReqMemHdr;
  typedef struct packed {
    t_cci_mpf_c1_ReqMemHdr hdr;
    t_cci_clData data;
    logic valid;
  } t_if_cci_mpf_c1_Tx;
  typedef struct packed {
    logic [63:0] hdr;
    logic valid;
  } t_if_cci_mpf_c0_Tx;
  typedef struct packed {
    logic [15:0] hdr;
    logic [63:0] data;
    logic mmioRdValid;
  } t_if_cci_c2_Tx;
  typedef struct packed {
    t_cci_vc vc_used;
    logic hit_miss;
    logic format;
    logic [1:0] cl_num;
    t_cci_rsp resp_type;
    t_cci_mdata mdata;
  } t_cci_c1_RspMemHdr;
  typedef struct packed {
    t_cci_c1_RspMemHdr hdr;
    logic rspValid;
  } t_if_cci_c1_Rx;
  function automatic logic cci_c1Rx_isWriteRsp(input t_if_cci_c1_Rx r);
    return r.rspValid && (r.hdr.resp_type == eRSP_WRLINE);
  endfunction
endpackage

// File: rtl/generic_processing_pkg.sv
// generic_processing_pkg: shared types and sizes for the generic processing pipeline.
package generic_processing_pkg;
  localparam int CL_DATA_W = 512;
  localparam int MAX_OUTSTANDING_DEFAULT = 64;
  typedef enum logic [1:0] {IDLE, RUN, WAIT_RSP, DONE} t_wr_state;
endpackage

// File: rtl/cci_mpf_if.sv
// cci_mpf_if: MPF channel bundle; to_fiu is the view of a module issuing requests toward the FIU.
interface cci_mpf_if;
  import cci_mpf_pkg::*;
  t_if_cci_mpf_c0_Tx c0Tx;
  t_if_cci_mpf_c1_Tx c1Tx;
  t_if_cci_c2_Tx c2Tx;
  logic c1TxAlmFull;
  t_if_cci_c1_Rx c1Rx;
  modport to_fiu (output c0Tx, c1Tx, c2Tx, input c1TxAlmFull, c1Rx);
endinterface

// File: rtl/wr_credit_counter.sv
// wr_credit_counter: tracks popped-but-unacknowledged writes; credit while below MAX_OUTSTANDING.
module wr_credit_counter #(
  parameter int MAX_OUTSTANDING = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic pop,
  input  logic rsp,
  output logic credit_ok
);
  logic [63:0] outstanding;
  always_ff @(posedge clk)
    if (!reset || clear) outstanding <= '0;
    else outstanding <= outstanding + 64'(pop) - 64'(rsp);
  assign credit_ok = outstanding < 64'(MAX_OUTSTANDING);
endmodule

// File: rtl/buffer_to_mpf_wr_sm.sv
// buffer_to_mpf_wr_sm: drains the output buffer to host memory as single-line MPF writes,
// then waits for every write acknowledgement before raising done.
module buffer_to_mpf_wr_sm
  import generic_processing_pkg::*, cci_mpf_pkg::*;
#(
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
  parameter logic [15:0] MDATA_TAG = 16'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [63:0]          data_length,
  input  t_cci_clAddr          first_clAddr,
  output logic                 done,
  cci_mpf_if.to_fiu            fiu,
  output logic                 buffer_rd_enable,
  input  logic [CL_DATA_W-1:0] buffer_data,
  input  logic                 buffer_empty
);
  t_wr_state state;
  logic [63:0] len_q, req_cnt, rsp_cnt, pop_cnt;
  t_cci_clAddr base_q;
  logic wr_valid, credit_ok, rsp, start;
  t_if_cci_mpf_c1_Tx c1_tx;
  assign start = (state == IDLE) && run;
  assign rsp = ((state == RUN) || (state == WAIT_RSP)) && cci_c1Rx_isWriteRsp(fiu.c1Rx);
  assign buffer_rd_enable = (state == RUN) && !buffer_empty && !fiu.c1TxAlmFull &&
                            (pop_cnt < len_q) && credit_ok;
  wr_credit_counter #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_credit (
    .clk(clk),
    .reset(reset),
    .clear(start),
    .pop(buffer_rd_enable),
    .rsp(rsp),
    .credit_ok(credit_ok)
  );
  // Buffer data arrives the cycle after the pop, exactly when the registered valid rises.
  always_comb begin
    c1_tx = '0;
    c1_tx.valid = wr_valid;
    c1_tx.data = buffer_data;
    c1_tx.hdr.addrIsVirtual = 1'b1;
    c1_tx.hdr.vc_sel = eVC_VA;
    c1_tx.hdr.sop = 1'b1;
    c1_tx.hdr.cl_len = eCL_LEN_1;
    c1_tx.hdr.req_type = eREQ_WRLINE_I;
    c1_tx.hdr.address = base_q + req_cnt[CCI_CLADDR_WIDTH-1:0];
    c1_tx.hdr.mdata = MDATA_TAG;
  end
  assign fiu.c1Tx = c1_tx;
  assign fiu.c0Tx = '0;
  assign fiu.c2Tx = '0;
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      done <= 1'b0;
      wr_valid <= 1'b0;
      len_q <= '0;
      base_q <= '0;
      req_cnt <= '0;
      rsp_cnt <= '0;
      pop_cnt <= '0;
    end else begin
      wr_valid <= buffer_rd_enable;
      req_cnt <= start ? '0 : req_cnt + 64'(wr_valid);
      rsp_cnt <= start ? '0 : rsp_cnt + 64'(rsp);
      pop_cnt <= start ? '0 : pop_cnt + 64'(buffer_rd_enable);
      case (state)
        IDLE: if (run) begin
          len_q <= data_length;
          base_q <= first_clAddr;
          done <= 1'b0;
          state <= (data_length != '0) ? RUN : DONE;
        end
        RUN: if (req_cnt == len_q) state <= WAIT_RSP;
        WAIT_RSP: if (rsp_cnt == len_q) state <= DONE;
        default: begin
          done <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
endmodule
